div_scheduler: RTL and testbench

DIV_SCHEDULER -- requirements
Module: div_scheduler

---
 rtl/div_sched_pkg.sv | 52 +++++
 rtl/div_scheduler_if.sv | 36 +++
 rtl/div_result_cache.sv | 45 ++++
 rtl/div_scheduler.sv | 141 ++++++++++++++
 tb/tb_div_scheduler.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_sched_pkg.sv
// Shared types, operation codes and helpers for the two-requester divider scheduler.
// Optional result cache is enabled by defining DIV_RESULT_CACHE_EN.
package div_sched_pkg;

  localparam int unsigned NUM_REQ      = 2;
  localparam int unsigned DIV_OP_WIDTH = 2;

  typedef logic [DIV_OP_WIDTH-1:0] div_op_t;

  localparam div_op_t DIV_OP_DIV  = 2'd0;
  localparam div_op_t DIV_OP_DIVU = 2'd1;
  localparam div_op_t DIV_OP_REM  = 2'd2;
  localparam div_op_t DIV_OP_REMU = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
`ifdef DIV_RESULT_CACHE_EN
    S_CAPT,
`endif
    S_RESP
  } state_t;

  typedef struct packed {
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        sgn;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        dbz;
  } cache_entry_t;

  // Companion operation sharing the same division: quotient <-> remainder.
  function automatic div_op_t pair_op(input div_op_t op);
    case (op)
      DIV_OP_DIV:  return DIV_OP_REM;
      DIV_OP_REM:  return DIV_OP_DIV;
      DIV_OP_DIVU: return DIV_OP_REMU;
      default:     return DIV_OP_DIVU;
    endcase
  endfunction

  function automatic logic op_signed(input div_op_t op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic op_is_rem(input div_op_t op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/div_scheduler_if.sv
// Requester and divider handshake bundle for div_scheduler.
// master = scheduler side, slave = requesters plus shared divider.
interface div_scheduler_if;
  import div_sched_pkg::*;

  logic [NUM_REQ-1:0]                   req_valid;
  logic [NUM_REQ-1:0][31:0]             req_dividend;
  logic [NUM_REQ-1:0][31:0]             req_divisor;
  logic [NUM_REQ-1:0][DIV_OP_WIDTH-1:0] req_op;
  logic [NUM_REQ-1:0]                   req_ready;
  logic [31:0]                          req_result;
  logic                                 req_dbz;

  logic                                 div_valid;
  logic [31:0]                          div_dividend;
  logic [31:0]                          div_divisor;
  logic [DIV_OP_WIDTH-1:0]              div_op;
  logic [31:0]                          div_result;
  logic                                 div_ready;
  logic                                 div_dbz;

  modport master (
    input  req_valid, req_dividend, req_divisor, req_op,
    output req_ready, req_result, req_dbz,
    output div_valid, div_dividend, div_divisor, div_op,
    input  div_result, div_ready, div_dbz
  );

  modport slave (
    output req_valid, req_dividend, req_divisor, req_op,
    input  req_ready, req_result, req_dbz,
    input  div_valid, div_dividend, div_divisor, div_op,
    output div_result, div_ready, div_dbz
  );

endinterface

// File: rtl/div_result_cache.sv
// One-entry cache of the last completed division (both quotient and remainder).
module div_result_cache
  import div_sched_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        fill,
  input  logic [31:0] fill_dividend,
  input  logic [31:0] fill_divisor,
  input  logic        fill_signed,
  input  logic [31:0] fill_quot,
  input  logic [31:0] fill_rem,
  input  logic        fill_dbz,
  input  logic [31:0] lookup_dividend,
  input  logic [31:0] lookup_divisor,
  input  logic        lookup_signed,
  output logic        hit,
  output logic [31:0] hit_quot,
  output logic [31:0] hit_rem,
  output logic        hit_dbz
);

  cache_entry_t entry;
  logic         entry_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      entry_valid <= 1'b0;
      entry       <= '0;
    end else if (fill) begin
      entry_valid <= 1'b1;
      entry       <= '{dividend: fill_dividend, divisor: fill_divisor, sgn: fill_signed,
                       quot: fill_quot, rem: fill_rem, dbz: fill_dbz};
    end
  end

  always_comb begin
    hit      = entry_valid && (entry.dividend == lookup_dividend) &&
               (entry.divisor == lookup_divisor) && (entry.sgn == lookup_signed);
    hit_quot = entry.quot;
    hit_rem  = entry.rem;
    hit_dbz  = entry.dbz;
  end

endmodule

// File: rtl/div_scheduler.sv
// Round-robin scheduler sharing one iterative divider between two requesters.
// Define DIV_RESULT_CACHE_EN to add a one-entry quotient/remainder cache.
module div_scheduler
  import div_sched_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  div_scheduler_if.master bus
);

  state_t      state, state_nx;
  logic        rr_ptr;
  logic        grant;
  logic        sel;
  logic [31:0] lat_dividend;
  logic [31:0] lat_divisor;
  div_op_t     lat_op;
  logic [31:0] resp_result;
  logic        resp_dbz;
  logic        hit;
  logic [31:0] hit_result;
  logic        hit_dbz;

  // A lone requester wins outright; a tie goes to rr_ptr.
  always_comb begin
    sel = rr_ptr;
    if (bus.req_valid == 2'b01) begin
      sel = 1'b0;
    end else if (bus.req_valid == 2'b10) begin
      sel = 1'b1;
    end
  end

`ifdef DIV_RESULT_CACHE_EN
  logic        cache_hit;
  logic        fill;
  logic [31:0] fill_quot;
  logic [31:0] fill_rem;
  logic [31:0] hit_quot;
  logic [31:0] hit_rem;

  // In CAPT the divider output shows the companion of the op captured in WAIT.
  assign fill       = (state == S_CAPT);
  assign fill_quot  = op_is_rem(lat_op) ? bus.div_result : resp_result;
  assign fill_rem   = op_is_rem(lat_op) ? resp_result : bus.div_result;
  assign hit        = cache_hit && (|bus.req_valid);
  assign hit_result = op_is_rem(bus.req_op[sel]) ? hit_rem : hit_quot;

  div_result_cache u_cache (
    .clk             (clk),
    .resetn          (resetn),
    .fill            (fill),
    .fill_dividend   (lat_dividend),
    .fill_divisor    (lat_divisor),
    .fill_signed     (op_signed(lat_op)),
    .fill_quot       (fill_quot),
    .fill_rem        (fill_rem),
    .fill_dbz        (resp_dbz),
    .lookup_dividend (bus.req_dividend[sel]),
    .lookup_divisor  (bus.req_divisor[sel]),
    .lookup_signed   (op_signed(bus.req_op[sel])),
    .hit             (cache_hit),
    .hit_quot        (hit_quot),
    .hit_rem         (hit_rem),
    .hit_dbz         (hit_dbz)
  );
`else
  assign hit        = 1'b0;
  assign hit_result = '0;
  assign hit_dbz    = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (|bus.req_valid) state_nx = hit ? S_RESP : S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
`ifdef DIV_RESULT_CACHE_EN
      S_WAIT:  if (bus.div_ready) state_nx = S_CAPT;
      S_CAPT:  state_nx = S_RESP;
`else
      S_WAIT:  if (bus.div_ready) state_nx = S_RESP;
`endif
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      rr_ptr       <= 1'b0;
      grant        <= 1'b0;
      lat_dividend <= '0;
      lat_divisor  <= '0;
      lat_op       <= '0;
      resp_result  <= '0;
      resp_dbz     <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && (|bus.req_valid)) begin
        grant        <= sel;
        rr_ptr       <= ~sel;
        lat_dividend <= bus.req_dividend[sel];
        lat_divisor  <= bus.req_divisor[sel];
        lat_op       <= bus.req_op[sel];
        if (hit) begin
          resp_result <= hit_result;
          resp_dbz    <= hit_dbz;
        end
      end
      if (state == S_WAIT && bus.div_ready) begin
        resp_result <= bus.div_result;
        resp_dbz    <= bus.div_dbz;
      end
    end
  end

  always_comb begin
    bus.req_ready    = '0;
    bus.req_result   = '0;
    bus.req_dbz      = 1'b0;
    bus.div_valid    = 1'b0;
    bus.div_dividend = lat_dividend;
    bus.div_divisor  = lat_divisor;
    bus.div_op       = lat_op;
    case (state)
      S_ISSUE: bus.div_valid = 1'b1;
`ifdef DIV_RESULT_CACHE_EN
      S_CAPT:  bus.div_op = pair_op(lat_op);
`endif
      S_RESP: begin
        bus.req_ready[grant] = 1'b1;
        bus.req_result       = resp_result;
        bus.req_dbz          = resp_dbz;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_div_scheduler.sv
// Scoreboard bench for div_scheduler with a behavioural variable-latency divider.
module tb_div_scheduler;
  import div_sched_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  div_scheduler_if bus ();

  div_scheduler dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    int          idx;
    div_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        dbz;
  } txn_t;

  txn_t pend0[$];
  txn_t pend1[$];
  txn_t exp_q[$];
  int   resp_cyc[$];
  int   total  = 0;
  int   bad    = 0;
  int   dv_cnt = 0;
  int   cyc    = 0;
  int   tb_lat = 3;

  // Behavioural divider: RISC-V M semantics, result muxed by the live div_op.
  logic [31:0] q_q, r_q;
  logic        dbz_q, rdy_q, busy;
  int          cnt;

  function automatic logic [63:0] ref_div(input div_op_t op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else if (op == DIV_OP_DIV || op == DIV_OP_REM) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = '0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  assign bus.div_result = (bus.div_op == DIV_OP_REM || bus.div_op == DIV_OP_REMU) ? r_q : q_q;
  assign bus.div_ready  = rdy_q;
  assign bus.div_dbz    = dbz_q;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy  <= 1'b0;
      cnt   <= 0;
      rdy_q <= 1'b0;
      q_q   <= '0;
      r_q   <= '0;
      dbz_q <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (bus.div_valid) begin
        {q_q, r_q} <= ref_div(bus.div_op, bus.div_dividend, bus.div_divisor);
        dbz_q      <= (bus.div_divisor == 32'd0);
        cnt        <= tb_lat;
        busy       <= 1'b1;
      end else if (busy) begin
        if (cnt <= 1) begin
          rdy_q <= 1'b1;
          busy  <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.div_valid) dv_cnt <= dv_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic present(input txn_t t);
    bus.req_op[t.idx]       = t.op;
    bus.req_dividend[t.idx] = t.a;
    bus.req_divisor[t.idx]  = t.b;
    bus.req_valid[t.idx]    = 1'b1;
  endtask

  task automatic issue(input int idx, input div_op_t op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic dbz);
    txn_t t;
    t.idx = idx; t.op = op; t.a = a; t.b = b; t.res = res; t.dbz = dbz;
    exp_q.push_back(t);
    if (idx == 0) pend0.push_back(t);
    else          pend1.push_back(t);
  endtask

  // Requesters: hold the head of each queue valid until its req_ready pulse.
  always @(negedge clk) begin
    if (!resetn) begin
      bus.req_valid    = '0;
      bus.req_op       = '0;
      bus.req_dividend = '0;
      bus.req_divisor  = '0;
    end else begin
      if (bus.req_ready[0] && pend0.size() > 0) void'(pend0.pop_front());
      if (bus.req_ready[1] && pend1.size() > 0) void'(pend1.pop_front());
      if (pend0.size() > 0) present(pend0[0]); else bus.req_valid[0] = 1'b0;
      if (pend1.size() > 0) present(pend1[0]); else bus.req_valid[1] = 1'b0;
    end
  end

  // Monitor: every response is matched against the oldest expectation.
  always @(negedge clk) begin
    if (resetn && (bus.req_ready != 2'b00)) begin
      txn_t t;
      int   idx;
      check("ready_onehot", 32'($onehot(bus.req_ready)), 32'd1);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got ready=%b result=%h expected no response",
                 bus.req_ready, bus.req_result);
      end else begin
        t   = exp_q.pop_front();
        idx = bus.req_ready[1] ? 1 : 0;
        check("resp_idx", 32'(idx), 32'(t.idx));
        check("resp_result", bus.req_result, t.res);
        check("resp_dbz", 32'(bus.req_dbz), 32'(t.dbz));
        resp_cyc.push_back(cyc);
      end
    end
  end

  task automatic wait_done(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s: timeout, got %0d responses missing expected 0", name, exp_q.size());
      exp_q.delete();
      pend0.delete();
      pend1.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int d0;
    int n;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_req_result", bus.req_result, 32'd0);
    check("rst_req_dbz", 32'(bus.req_dbz), 32'd0);
    check("rst_div_valid", 32'(bus.div_valid), 32'd0);
    check("rst_div_dividend", bus.div_dividend, 32'd0);
    check("rst_div_divisor", bus.div_divisor, 32'd0);
    check("rst_div_op", 32'(bus.div_op), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Signed quotient/remainder pair raised together; req0 wins after reset.
    d0 = dv_cnt;
    issue(0, DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    issue(1, DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    wait_done("pair");
`ifdef DIV_RESULT_CACHE_EN
    check("pair_div_pulses", 32'(dv_cnt - d0), 32'd1);
    if (resp_cyc.size() >= 2)
      check("pair_hit_gap", 32'(resp_cyc[resp_cyc.size()-1] - resp_cyc[resp_cyc.size()-2]), 32'd2);
`else
    check("pair_div_pulses", 32'(dv_cnt - d0), 32'd2);
`endif

    // Both held valid: grants alternate 0,1,0,1,...
    issue(0, DIV_OP_DIVU, 32'd20,  32'd4, 32'd5,  1'b0);
    issue(1, DIV_OP_REMU, 32'd20,  32'd3, 32'd2,  1'b0);
    issue(0, DIV_OP_DIVU, 32'd30,  32'd4, 32'd7,  1'b0);
    issue(1, DIV_OP_REMU, 32'd31,  32'd3, 32'd1,  1'b0);
    issue(0, DIV_OP_DIVU, 32'd40,  32'd4, 32'd10, 1'b0);
    issue(1, DIV_OP_REMU, 32'd43,  32'd5, 32'd3,  1'b0);
    issue(0, DIV_OP_DIVU, 32'd50,  32'd4, 32'd12, 1'b0);
    issue(1, DIV_OP_REMU, 32'd100, 32'd9, 32'd1,  1'b0);
    wait_done("round_robin");

    d0 = dv_cnt;
    issue(0, DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0);
    wait_done("divu_basic");
    check("divu_div_pulses", 32'(dv_cnt - d0), 32'd1);

    issue(0, DIV_OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
    wait_done("divu_zero");
    issue(0, DIV_OP_REMU, 32'd5, 32'd0, 32'd5, 1'b1);
    wait_done("remu_zero");
    issue(0, DIV_OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b1);
    wait_done("rem_zero");

    // Reset in the middle of a long division.
    tb_lat = 20;
    d0 = dv_cnt;
    issue(0, DIV_OP_DIVU, 32'd1000, 32'd10, 32'd100, 1'b0);
    n = 0;
    while (dv_cnt == d0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("midreset_issued", 32'(dv_cnt - d0), 32'd1);
    repeat (3) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    check("midrst_req_result", bus.req_result, 32'd0);
    check("midrst_req_dbz", 32'(bus.req_dbz), 32'd0);
    check("midrst_div_valid", 32'(bus.div_valid), 32'd0);
    check("midrst_div_dividend", bus.div_dividend, 32'd0);
    check("midrst_div_divisor", bus.div_divisor, 32'd0);
    check("midrst_div_op", 32'(bus.div_op), 32'd0);
    exp_q.delete();
    pend0.delete();
    pend1.delete();
    tb_lat = 3;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    issue(0, DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b0);
    wait_done("after_reset");

    // Same request twice back to back.
    d0 = dv_cnt;
    issue(0, DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0);
    issue(0, DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0);
    wait_done("repeat");
`ifdef DIV_RESULT_CACHE_EN
    check("repeat_div_pulses", 32'(dv_cnt - d0), 32'd1);
`else
    check("repeat_div_pulses", 32'(dv_cnt - d0), 32'd2);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
